// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin arbiter that shares one 16-entry register-source read mux
// among NUM_REQ requesters, with a registered read return one cycle after grant.
//
// Ports:
//   clk, reset         rising-edge clock; synchronous active-high reset
//   req      [N]       per-requester read request, held until granted
//   req_addr [4N]      4-bit register index per requester, slice i = [4i+3:4i]
//   gnt      [N]       one-hot combinational grant (grant implies accept)
//   mux_sel  [4]       combinational select to the register-source mux
//   mux_data [DATA_W]  mux output, combinational from mux_sel
//   rd_data  [DATA_W]  registered read data
//   rd_valid [N]       one-hot owner of rd_data
//   req_lock [N]       burst-hold request (only when REQ_LOCK_EN is defined)
//
// Build option: define REQ_LOCK_EN to add req_lock and the ARB/LOCKED burst FSM
// (at most MAX_LOCK consecutive grants to a locked owner).
module regfile_read_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [3:0]           mux_sel,
  input  logic [DATA_W-1:0]    mux_data,
  output logic [DATA_W-1:0]    rd_data,
  output logic [NUM_REQ-1:0]   rd_valid
`ifdef REQ_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]   req_lock
`endif
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time guard on the supported parameter range.
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LOCK < 2) begin : g_bad_param
    $error("regfile_read_arbiter: NUM_REQ must be 2..8 and MAX_LOCK >= 2");
  end

  // Unpack the flat address bus into one entry per requester.
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
  end

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  logic               rr_found;
  logic [PTR_W-1:0]   rr_win;
  logic               grant_en;
  logic [PTR_W-1:0]   win;

`ifdef REQ_LOCK_EN
  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [LOCK_W-1:0]  lock_inc;
`endif

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (32'(p) == NUM_REQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Round-robin scan: first requester at or after ptr, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_p;
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = 0;
    idx_p    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(ptr_q) + k) % NUM_REQ;
      idx_p = PTR_W'(idx);
      if (!rr_found && req[idx_p]) begin
        rr_found = 1'b1;
        rr_win   = idx_p;
      end
    end
  end

  // Grant selection, lock FSM next-state and read-return next-state.
  always_comb begin
    win        = rr_win;
    grant_en   = rr_found;
    ptr_d      = ptr_q;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    gnt        = '0;
    mux_sel    = 4'd0;
`ifdef REQ_LOCK_EN
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    lock_inc   = lock_cnt_q + LOCK_W'(1);
    case (state_q)
      ST_ARB: begin
        if (rr_found && req_lock[rr_win]) begin
          state_d    = ST_LOCKED;
          owner_d    = rr_win;
          lock_cnt_d = LOCK_W'(1);
        end
      end
      ST_LOCKED: begin
        // Only the owner can be served; everyone else waits out the burst.
        win      = owner_q;
        grant_en = req[owner_q];
        if (grant_en) lock_cnt_d = lock_inc;
        if (!req_lock[owner_q] || !req[owner_q] ||
            (grant_en && lock_inc == LOCK_W'(MAX_LOCK))) begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
          ptr_d      = ptr_next(owner_q);
        end
      end
      default: state_d = ST_ARB;
    endcase
`endif
    // A request seen during reset is dropped, not deferred.
    if (reset) grant_en = 1'b0;
    if (grant_en) begin
      gnt[win]   = 1'b1;
      mux_sel    = addr_arr[win];
      ptr_d      = ptr_next(win);
      rd_valid_d = gnt;
      rd_data_d  = mux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
`ifdef REQ_LOCK_EN
      state_q    <= ST_ARB;
      owner_q    <= '0;
      lock_cnt_q <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef REQ_LOCK_EN
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter (NUM_REQ=4, DATA_W=32); the register-source mux is
// modelled as Q[n] = 32'hA000_0000 + n.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  mux_sel;
  logic [31:0] mux_data;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;
`ifdef REQ_LOCK_EN
  logic [3:0]  req_lock;
`endif

  always #5 clk = ~clk;

  assign mux_data = 32'hA000_0000 + 32'(mux_sel);

  regfile_read_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_LOCK(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .mux_sel  (mux_sel),
    .mux_data (mux_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef REQ_LOCK_EN
    ,
    .req_lock (req_lock)
`endif
  );

  // One row = one clock cycle; rd_* expectations are the result of the previous row.
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  sel;
    logic [3:0]  vld;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //           rst   req    addr      gnt    sel   vld    data
    vecs[0]  = '{1'b1, 4'hF, 16'h4321, 4'h0, 4'd0, 4'h0, 32'h0};         // reset drops requests
    vecs[1]  = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'd0, 4'h0, 32'h0};
    vecs[2]  = '{1'b0, 4'h4, 16'h0500, 4'h4, 4'd5, 4'h0, 32'h0};         // single req2, addr 5
    vecs[3]  = '{1'b0, 4'h0, 16'h0000, 4'h0, 4'd0, 4'h4, 32'hA000_0005};
    vecs[4]  = '{1'b0, 4'h8, 16'h4321, 4'h8, 4'd4, 4'h0, 32'hA000_0005}; // ptr 3, data held
    vecs[5]  = '{1'b0, 4'hF, 16'h4321, 4'h1, 4'd1, 4'h8, 32'hA000_0004}; // full rotation
    vecs[6]  = '{1'b0, 4'hF, 16'h4321, 4'h2, 4'd2, 4'h1, 32'hA000_0001};
    vecs[7]  = '{1'b0, 4'hF, 16'h4321, 4'h4, 4'd3, 4'h2, 32'hA000_0002};
    vecs[8]  = '{1'b0, 4'hF, 16'h4321, 4'h8, 4'd4, 4'h4, 32'hA000_0003};
    vecs[9]  = '{1'b0, 4'hF, 16'h4321, 4'h1, 4'd1, 4'h8, 32'hA000_0004};
    vecs[10] = '{1'b0, 4'h2, 16'h4321, 4'h2, 4'd2, 4'h1, 32'hA000_0001}; // ptr -> 2
    vecs[11] = '{1'b0, 4'h3, 16'h4321, 4'h1, 4'd1, 4'h2, 32'hA000_0002}; // wrap to req0
    vecs[12] = '{1'b0, 4'h3, 16'h4321, 4'h2, 4'd2, 4'h1, 32'hA000_0001}; // then req1
    vecs[13] = '{1'b1, 4'h2, 16'h4321, 4'h0, 4'd0, 4'h2, 32'hA000_0002}; // reset on accept
    vecs[14] = '{1'b0, 4'h0, 16'h4321, 4'h0, 4'd0, 4'h0, 32'h0};         // read discarded
    vecs[15] = '{1'b0, 4'hA, 16'h4321, 4'h2, 4'd2, 4'h0, 32'h0};         // ptr back at 0
    vecs[16] = '{1'b0, 4'h0, 16'h4321, 4'h0, 4'd0, 4'h2, 32'hA000_0002};
    vecs[17] = '{1'b0, 4'h0, 16'h4321, 4'h0, 4'd0, 4'h0, 32'hA000_0002}; // data holds

    reset    = 1'b1;
    req      = 4'h0;
    req_addr = 16'h0;
`ifdef REQ_LOCK_EN
    req_lock = 4'h0;
`endif
    tick();

    for (int i = 0; i < NV; i++) begin
      reset    = vecs[i].rst;
      req      = vecs[i].req;
      req_addr = vecs[i].addr;
      #1;
      chk($sformatf("row%0d gnt", i),      32'(gnt),      32'(vecs[i].gnt));
      chk($sformatf("row%0d mux_sel", i),  32'(mux_sel),  32'(vecs[i].sel));
      chk($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].vld));
      chk($sformatf("row%0d rd_data", i),  rd_data,       vecs[i].data);
      chk($sformatf("row%0d gnt_vs_req", i), 32'(gnt & ~req), 32'h0);
      tick();
    end

    // A lone requester streaming back-to-back reads with a changing address.
    reset = 1'b0;
    req   = 4'h1;
    for (int c = 0; c < 3; c++) begin
      req_addr = {12'h0, 4'(4'd7 + 4'(c))};
      #1;
      chk($sformatf("stream%0d gnt", c), 32'(gnt), 32'h1);
      if (c > 0) begin
        chk($sformatf("stream%0d rd_valid", c), 32'(rd_valid), 32'h1);
        chk($sformatf("stream%0d rd_data", c), rd_data, 32'hA000_0000 + 32'(6 + c));
      end
      tick();
    end
    req = 4'h0;
    #1;
    chk("stream_tail rd_data", rd_data, 32'hA000_0009);
    tick();
    chk("stream_idle rd_valid", 32'(rd_valid), 32'h0);

`ifdef REQ_LOCK_EN
    // Locked owner gets exactly MAX_LOCK grants, then the other requester is served.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    req      = 4'h3;
    req_addr = 16'h0021;
    req_lock = 4'h1;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("lock%0d gnt", c), 32'(gnt), (c < 8) ? 32'h1 : 32'h2);
      tick();
    end
    req      = 4'h0;
    req_lock = 4'h0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
